// File: rtl/memory_island_bank_xbar_pkg.sv
// Shared configuration and address-decode helpers for the memory island bank crossbar.
// Words are interleaved across banks: [ word addr | bank idx | byte offset ].
package memory_island_pkg;

  typedef struct packed {
    int unsigned num_req;
    int unsigned num_banks;
    int unsigned data_width;
    int unsigned addr_width;
    int unsigned bank_addr_width;
    int unsigned bank_latency;
  } mem_cfg_t;

  localparam mem_cfg_t DefaultCfg = '{
    num_req:         4,
    num_banks:       4,
    data_width:      64,
    addr_width:      32,
    bank_addr_width: 10,
    bank_latency:    1
  };

  localparam int unsigned OffW  = $clog2(DefaultCfg.data_width / 8);
  localparam int unsigned BankW = (DefaultCfg.num_banks > 1) ? $clog2(DefaultCfg.num_banks) : 0;

  // Field widths default to the package config; parameterised users pass their own.
  function automatic int unsigned bank_idx(input logic [63:0] addr,
                                           input int unsigned off_w  = OffW,
                                           input int unsigned bank_w = BankW);
    logic [63:0] mask;
    mask = (64'd1 << bank_w) - 64'd1;
    return 32'((addr >> off_w) & mask);
  endfunction

  function automatic logic [63:0] bank_word_addr(input logic [63:0] addr,
                                                 input int unsigned off_w  = OffW,
                                                 input int unsigned bank_w = BankW,
                                                 input int unsigned word_w = DefaultCfg.bank_addr_width);
    logic [63:0] mask;
    mask = (64'd1 << word_w) - 64'd1;
    return (addr >> (off_w + bank_w)) & mask;
  endfunction

endpackage

// File: rtl/memory_island_bank_xbar_if.sv
// Requester-side and bank-side buses of the bank crossbar.
// master = requesters plus SRAM banks, slave = the crossbar itself.
interface memory_island_bank_xbar_if #(
  parameter int unsigned NumReq        = 4,
  parameter int unsigned NumBanks      = 4,
  parameter int unsigned DataWidth     = 64,
  parameter int unsigned AddrWidth     = 32,
  parameter int unsigned BankAddrWidth = 10
);
  logic [NumReq-1:0]                  req_valid_i;
  logic [NumReq-1:0]                  req_ready_o;
  logic [NumReq*AddrWidth-1:0]        req_addr_i;
  logic [NumReq-1:0]                  req_we_i;
  logic [NumReq*DataWidth/8-1:0]      req_be_i;
  logic [NumReq*DataWidth-1:0]        req_wdata_i;
  logic [NumReq-1:0]                  rsp_valid_o;
  logic [NumReq*DataWidth-1:0]        rsp_rdata_o;
  logic [NumBanks-1:0]                bank_req_o;
  logic [NumBanks-1:0]                bank_we_o;
  logic [NumBanks*BankAddrWidth-1:0]  bank_addr_o;
  logic [NumBanks*DataWidth/8-1:0]    bank_be_o;
  logic [NumBanks*DataWidth-1:0]      bank_wdata_o;
  logic [NumBanks*DataWidth-1:0]      bank_rdata_i;

  modport master (
    output req_valid_i, req_addr_i, req_we_i, req_be_i, req_wdata_i, bank_rdata_i,
    input  req_ready_o, rsp_valid_o, rsp_rdata_o,
    input  bank_req_o, bank_we_o, bank_addr_o, bank_be_o, bank_wdata_o
  );

  modport slave (
    input  req_valid_i, req_addr_i, req_we_i, req_be_i, req_wdata_i, bank_rdata_i,
    output req_ready_o, rsp_valid_o, rsp_rdata_o,
    output bank_req_o, bank_we_o, bank_addr_o, bank_be_o, bank_wdata_o
  );
endinterface

// File: rtl/memory_island_bank_xbar_rr_arbiter.sv
// Round-robin arbiter: combinational grant, registered priority pointer.
// Pointer moves to one past the winner on each grant and holds while idle.
module memory_island_rr_arbiter #(
  parameter int unsigned N = 4,
  localparam int unsigned IdxW = (N > 1) ? $clog2(N) : 1
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic [N-1:0]    req_i,
  output logic [N-1:0]    gnt_o,
  output logic [IdxW-1:0] gnt_idx_o,
  output logic            gnt_valid_o
);

  logic [IdxW-1:0] ptr_q;
  logic [IdxW-1:0] cand;

  always_comb begin
    gnt_o       = '0;
    gnt_idx_o   = '0;
    gnt_valid_o = 1'b0;
    cand        = '0;
    for (int unsigned k = 0; k < N; k++) begin
      cand = IdxW'((32'(ptr_q) + k) % N);
      if (!gnt_valid_o && req_i[cand]) begin
        gnt_valid_o = 1'b1;
        gnt_o[cand] = 1'b1;
        gnt_idx_o   = cand;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ptr_q <= '0;
    end else if (gnt_valid_o) begin
      ptr_q <= (32'(gnt_idx_o) == N - 1) ? '0 : gnt_idx_o + 1'b1;
    end
  end

endmodule

// File: rtl/memory_island_bank_xbar.sv
// Requester-to-bank crossbar: per-bank round-robin grant, fixed-latency in-order responses.
// Banks are driven in the grant cycle; responses need no backpressure, so ready never waits on them.
module memory_island_bank_xbar
  import memory_island_pkg::*;
#(
  parameter int unsigned NumReq        = 4,
  parameter int unsigned NumBanks      = 4,
  parameter int unsigned DataWidth     = 64,
  parameter int unsigned AddrWidth     = 32,
  parameter int unsigned BankAddrWidth = 10,
  parameter int unsigned BankLatency   = 1
) (
  input logic clk_i,
  input logic rst_ni,
  memory_island_bank_xbar_if.slave bus
);

  localparam int unsigned BeW      = DataWidth / 8;
  localparam int unsigned OffBits  = $clog2(BeW);
  localparam int unsigned BankBits = (NumBanks > 1) ? $clog2(NumBanks) : 0;
  localparam int unsigned BankIdxW = (BankBits > 0) ? BankBits : 1;
  localparam int unsigned ReqIdxW  = (NumReq > 1) ? $clog2(NumReq) : 1;

  typedef struct packed {
    logic                vld;
    logic                is_read;
    logic [BankIdxW-1:0] bank;
  } rsp_stage_t;

  logic [NumReq-1:0][BankIdxW-1:0]      req_bank;
  logic [NumReq-1:0][BankAddrWidth-1:0] req_word;
  logic [NumBanks-1:0][NumReq-1:0]      bank_cand;
  logic [NumBanks-1:0][NumReq-1:0]      bank_gnt;
  logic [NumBanks-1:0][ReqIdxW-1:0]     gnt_idx;
  logic [NumBanks-1:0]                  gnt_vld;
  logic [NumReq-1:0]                    req_gnt;

  logic [NumBanks-1:0]                    bank_req;
  logic [NumBanks-1:0]                    bank_we;
  logic [NumBanks-1:0][BankAddrWidth-1:0] bank_addr;
  logic [NumBanks-1:0][BeW-1:0]           bank_be;
  logic [NumBanks-1:0][DataWidth-1:0]     bank_wdata;

  logic [NumReq-1:0]                      rsp_valid;
  logic [NumReq-1:0][DataWidth-1:0]       rsp_rdata;

  rsp_stage_t [BankLatency-1:0] pipe_q [NumReq];

  always_comb begin
    req_bank  = '0;
    req_word  = '0;
    bank_cand = '0;
    for (int unsigned r = 0; r < NumReq; r++) begin
      req_bank[r] = BankIdxW'(bank_idx(64'(bus.req_addr_i[r*AddrWidth +: AddrWidth]),
                                       OffBits, BankBits));
      req_word[r] = BankAddrWidth'(bank_word_addr(64'(bus.req_addr_i[r*AddrWidth +: AddrWidth]),
                                                  OffBits, BankBits, BankAddrWidth));
    end
    for (int unsigned b = 0; b < NumBanks; b++) begin
      for (int unsigned r = 0; r < NumReq; r++) begin
        bank_cand[b][r] = bus.req_valid_i[r] && (req_bank[r] == BankIdxW'(b));
      end
    end
  end

  for (genvar b = 0; b < NumBanks; b++) begin : g_bank
    memory_island_rr_arbiter #(.N(NumReq)) u_arb (
      .clk_i       (clk_i),
      .rst_ni      (rst_ni),
      .req_i       (bank_cand[b]),
      .gnt_o       (bank_gnt[b]),
      .gnt_idx_o   (gnt_idx[b]),
      .gnt_valid_o (gnt_vld[b])
    );
  end

  // A requester targets exactly one bank, so OR-ing per-bank grants is its ready.
  always_comb begin
    req_gnt = '0;
    for (int unsigned b = 0; b < NumBanks; b++) begin
      req_gnt = req_gnt | bank_gnt[b];
    end
  end

  always_comb begin
    bank_req   = '0;
    bank_we    = '0;
    bank_addr  = '0;
    bank_be    = '0;
    bank_wdata = '0;
    for (int unsigned b = 0; b < NumBanks; b++) begin
      if (gnt_vld[b]) begin
        bank_req[b]   = 1'b1;
        bank_we[b]    = bus.req_we_i[gnt_idx[b]];
        bank_addr[b]  = req_word[gnt_idx[b]];
        bank_be[b]    = bus.req_be_i[gnt_idx[b]*BeW +: BeW];
        bank_wdata[b] = bus.req_wdata_i[gnt_idx[b]*DataWidth +: DataWidth];
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      pipe_q <= '{default: '0};
    end else begin
      for (int unsigned r = 0; r < NumReq; r++) begin
        pipe_q[r][0] <= '{vld: req_gnt[r], is_read: !bus.req_we_i[r], bank: req_bank[r]};
        for (int unsigned s = 1; s < BankLatency; s++) begin
          pipe_q[r][s] <= pipe_q[r][s-1];
        end
      end
    end
  end

  // Last stage lines up with the bank's read data for the recorded bank.
  always_comb begin
    rsp_valid = '0;
    rsp_rdata = '0;
    for (int unsigned r = 0; r < NumReq; r++) begin
      rsp_valid[r] = pipe_q[r][BankLatency-1].vld;
      if (pipe_q[r][BankLatency-1].vld && pipe_q[r][BankLatency-1].is_read) begin
        rsp_rdata[r] = bus.bank_rdata_i[pipe_q[r][BankLatency-1].bank*DataWidth +: DataWidth];
      end
    end
  end

  assign bus.req_ready_o  = req_gnt;
  assign bus.rsp_valid_o  = rsp_valid;
  assign bus.rsp_rdata_o  = rsp_rdata;
  assign bus.bank_req_o   = bank_req;
  assign bus.bank_we_o    = bank_we;
  assign bus.bank_addr_o  = bank_addr;
  assign bus.bank_be_o    = bank_be;
  assign bus.bank_wdata_o = bank_wdata;

endmodule
